decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- ID stage of the 8-bit pipeline, sitting between the IF/ID register and EX.
- Decodes the fetched instruction and drives the register-file read addresses.
- Picks operands from the register file or from the MEM/WB bypass paths.
- Detects load-use hazards and registers the result into the ID/EX pipeline register it owns.

Parameters:
- DATA_W, 8, datapath width.
- RADDR_W, 2, register address width (4 registers; R3 is SP).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  the IF/ID register holds a real instruction.
- id_instr  in  8  instruction: opcode[7:4], ra[3:2], rb[1:0].
- flush  in  1  branch taken: kill ID/EX contents this edge.
- rf_ra  out  RADDR_W  register-file read address A; combinational, equals id_instr[3:2].
- rf_rb  out  RADDR_W  register-file read address B; combinational, equals id_instr[1:0].
- rf_rda  in  DATA_W  register-file read data A.
- rf_rdb  in  DATA_W  register-file read data B.
- mem_wr_en  in  1  EX/MEM instruction will write a register.
- mem_wr_addr  in  RADDR_W  destination of the EX/MEM instruction.
- mem_wr_data  in  DATA_W  result of the EX/MEM instruction (not valid for loads).
- mem_is_load  in  1  EX/MEM instruction is a load.
- wb_wr_en  in  1  writeback enable; same net as the register-file write enable.
- wb_wr_addr  in  RADDR_W  writeback address.
- wb_wr_data  in  DATA_W  writeback data.
- stall  out  1  combinational; holds PC and IF/ID this cycle.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_alu_op  out  3  ALU operation code.
- ex_opa  out  DATA_W  operand A.
- ex_opb  out  DATA_W  operand B.
- ex_rw  out  RADDR_W  destination register.
- ex_wr_en  out  1  instruction writes a register.
- ex_is_load  out  1  instruction is LD.
- ex_is_store  out  1  instruction is ST.
- ex_illegal  out  1  the instruction in ID/EX was a reserved opcode.

Behaviour:
- Reset, checked before anything else:
  - all ex_* outputs become 0.
  - ex_valid=0; ID/EX holds a bubble.
  - A reset mid-stall drops the stalled instruction. stall then deasserts combinationally because ex_valid=0.
- Decode (opcode -> reads / write / flags):
  - 0x0 NOP: reads none; writes none.
  - 0x1 MOV: reads rb; writes ra. alu_op=000, opa=0, opb=rb (ALU passes B through).
  - 0x2 ADD, 0x3 SUB, 0x4 AND, 0x5 OR: read ra and rb; write ra. alu_op = opcode-1 (001..100).
  - 0x6 LD: reads rb (address); writes ra; is_load=1; alu_op=000.
  - 0x7 ST: reads ra (data) and rb (address); writes none; is_store=1; alu_op=000.
  - 0x8-0xF: reserved; decoded as NOP with illegal=1, captured into ex_illegal.
- Operand select, per operand, in priority order:
  - EX/MEM bypass: mem_wr_en and mem_wr_addr equal to the read address, and mem_is_load=0.
  - WB bypass: wb_wr_en and matching wb_wr_addr. Needed because the register file writes at the same edge, so a same-cycle read returns the old value.
  - Otherwise the register-file data.
- Load-use hazard:
  - Condition: (ex_valid & ex_is_load & id_valid & the current instruction reads ex_rw), or (mem_wr_en & mem_is_load & id_valid & the current instruction reads mem_wr_addr).
  - Response: stall=1; ID/EX loads a bubble (ex_valid=0, ex_wr_en=0, ex_is_load=0, ex_is_store=0).
  - The same id_instr is re-evaluated next cycle.
  - A load followed immediately by a use stalls 2 cycles: 1 for the load in EX, 1 for the load in MEM. The operand then comes via WB bypass.
  - Only registers the instruction actually reads count. ST reading ra counts; MOV does not read ra.
- ID/EX update at every non-reset edge:
  - flush=1: bubble. Flush overrides stall; stall is forced to 0 while flush=1.
  - Else stall=1: bubble.
  - Else id_valid=0: bubble.
  - Else: load the decoded fields and the selected operands.
- Latency: 1 cycle, ID to EX.
- Width rules: operands are exactly DATA_W; no arithmetic in this stage.

Decomposition:
- Package isa_pkg holds:
  - the opcode constants (OP_NOP..OP_ST);
  - the ALU op constants;
  - the field-slice positions;
  - SP_REG=3.
- One sub-module: operand_bypass. It is the 3-way priority mux, instantiated once per operand.
- The decoder and the hazard logic stay inline.

Test Plan:
- Reset: rst=1 for 2 cycles, any inputs -> all ex_* = 0 and stall=0.
- WB bypass: rf R1=5, wb writes R1=9 in the same cycle, id_instr ADD R0,R1 (0x21) -> next cycle ex_opb=9.
- Bypass priority: mem_wr R2=0x33 and wb_wr R2=0x44 together, MOV R0,R2 (0x12) -> ex_opb=0x33, ex_alu_op=000, ex_rw=0.
- Load-use stall:
  - Stimulus: LD R1,[R2] (0x66) then ADD R0,R1 (0x21).
  - Required: stall=1 for 2 cycles and 2 bubbles in ID/EX.
  - Third cycle: ADD issues with ex_opb equal to the wb_wr_data of R1.
- Flush during stall: flush=1 on the first stall cycle -> stall=0 and ex_valid=0 next edge.
- Reserved opcode: 0xA5 with id_valid=1 -> ex_valid=1, ex_illegal=1, ex_wr_en=0.

Source files
------------

// File: rtl/isa_pkg.sv
// +------------------------------------------------------------------+
// | isa_pkg : opcodes, ALU codes, field positions, opcode decoder    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package isa_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_LD  = 4'h6;
  localparam logic [3:0] OP_ST  = 4'h7;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;

  localparam int OPC_HI = 7;
  localparam int OPC_LO = 4;
  localparam int RA_HI  = 3;
  localparam int RA_LO  = 2;
  localparam int RB_HI  = 1;
  localparam int RB_LO  = 0;

  localparam logic [1:0] SP_REG = 2'd3;

  typedef struct packed {
    logic       reads_a;
    logic       reads_b;
    logic       wr_en;
    logic       is_load;
    logic       is_store;
    logic       illegal;
    logic [2:0] alu_op;
  } dec_t;

  // Reserved opcodes fall into the default arm: no reads, no write, flagged.
  function automatic dec_t decode(input logic [3:0] op);
    dec_t d;
    d = '0;
    case (op)
      OP_NOP: d.alu_op = ALU_PASS;
      OP_MOV: begin d.reads_b = 1'b1; d.wr_en = 1'b1; d.alu_op = ALU_PASS; end
      OP_ADD: begin d.reads_a = 1'b1; d.reads_b = 1'b1; d.wr_en = 1'b1; d.alu_op = ALU_ADD; end
      OP_SUB: begin d.reads_a = 1'b1; d.reads_b = 1'b1; d.wr_en = 1'b1; d.alu_op = ALU_SUB; end
      OP_AND: begin d.reads_a = 1'b1; d.reads_b = 1'b1; d.wr_en = 1'b1; d.alu_op = ALU_AND; end
      OP_OR:  begin d.reads_a = 1'b1; d.reads_b = 1'b1; d.wr_en = 1'b1; d.alu_op = ALU_OR;  end
      OP_LD:  begin d.reads_b = 1'b1; d.wr_en = 1'b1; d.is_load = 1'b1; d.alu_op = ALU_PASS; end
      OP_ST:  begin d.reads_a = 1'b1; d.reads_b = 1'b1; d.is_store = 1'b1; d.alu_op = ALU_PASS; end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/operand_bypass.sv
// +------------------------------------------------------------------+
// | operand_bypass : EX/MEM > WB > register-file priority mux        |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module operand_bypass #(
  parameter int DATA_W  = 8,
  parameter int RADDR_W = 2
) (
  input  logic [RADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0]  rf_data,
  input  logic               mem_wr_en,
  input  logic               mem_is_load,
  input  logic [RADDR_W-1:0] mem_wr_addr,
  input  logic [DATA_W-1:0]  mem_wr_data,
  input  logic               wb_wr_en,
  input  logic [RADDR_W-1:0] wb_wr_addr,
  input  logic [DATA_W-1:0]  wb_wr_data,
  output logic [DATA_W-1:0]  data
);

  // A load in MEM has no data yet; the hazard logic stalls instead.
  always_comb begin
    data = rf_data;
    if (mem_wr_en && !mem_is_load && (mem_wr_addr == rd_addr)) begin
      data = mem_wr_data;
    end else if (wb_wr_en && (wb_wr_addr == rd_addr)) begin
      data = wb_wr_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// +------------------------------------------------------------------+
// | decode_stage : ID stage - decode, bypass, load-use stall, ID/EX  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module decode_stage
  import isa_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int RADDR_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [7:0]         id_instr,
  input  logic               flush,
  output logic [RADDR_W-1:0] rf_ra,
  output logic [RADDR_W-1:0] rf_rb,
  input  logic [DATA_W-1:0]  rf_rda,
  input  logic [DATA_W-1:0]  rf_rdb,
  input  logic               mem_wr_en,
  input  logic [RADDR_W-1:0] mem_wr_addr,
  input  logic [DATA_W-1:0]  mem_wr_data,
  input  logic               mem_is_load,
  input  logic               wb_wr_en,
  input  logic [RADDR_W-1:0] wb_wr_addr,
  input  logic [DATA_W-1:0]  wb_wr_data,
  output logic               stall,
  output logic               ex_valid,
  output logic [2:0]         ex_alu_op,
  output logic [DATA_W-1:0]  ex_opa,
  output logic [DATA_W-1:0]  ex_opb,
  output logic [RADDR_W-1:0] ex_rw,
  output logic               ex_wr_en,
  output logic               ex_is_load,
  output logic               ex_is_store,
  output logic               ex_illegal
);

  logic [3:0]         opcode;
  logic [RADDR_W-1:0] ra;
  logic [RADDR_W-1:0] rb;
  dec_t               dec;
  logic [DATA_W-1:0]  byp_a;
  logic [DATA_W-1:0]  byp_b;
  logic               hz_ex;
  logic               hz_mem;
  logic               bubble;

  assign opcode = id_instr[OPC_HI:OPC_LO];
  assign ra     = id_instr[RA_HI:RA_LO];
  assign rb     = id_instr[RB_HI:RB_LO];
  assign rf_ra  = ra;
  assign rf_rb  = rb;
  assign dec    = decode(opcode);

  operand_bypass #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_byp_a (
    .rd_addr     (ra),
    .rf_data     (rf_rda),
    .mem_wr_en   (mem_wr_en),
    .mem_is_load (mem_is_load),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .wb_wr_en    (wb_wr_en),
    .wb_wr_addr  (wb_wr_addr),
    .wb_wr_data  (wb_wr_data),
    .data        (byp_a)
  );

  operand_bypass #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_byp_b (
    .rd_addr     (rb),
    .rf_data     (rf_rdb),
    .mem_wr_en   (mem_wr_en),
    .mem_is_load (mem_is_load),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .wb_wr_en    (wb_wr_en),
    .wb_wr_addr  (wb_wr_addr),
    .wb_wr_data  (wb_wr_data),
    .data        (byp_b)
  );

  // Only registers the instruction actually reads can create a load-use hazard.
  assign hz_ex  = ex_valid && ex_is_load &&
                  ((dec.reads_a && (ra == ex_rw)) || (dec.reads_b && (rb == ex_rw)));
  assign hz_mem = mem_wr_en && mem_is_load &&
                  ((dec.reads_a && (ra == mem_wr_addr)) || (dec.reads_b && (rb == mem_wr_addr)));
  assign stall  = id_valid && (hz_ex || hz_mem) && !flush;
  assign bubble = flush || stall || !id_valid;

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      ex_valid    <= 1'b0;
      ex_alu_op   <= '0;
      ex_opa      <= '0;
      ex_opb      <= '0;
      ex_rw       <= '0;
      ex_wr_en    <= 1'b0;
      ex_is_load  <= 1'b0;
      ex_is_store <= 1'b0;
      ex_illegal  <= 1'b0;
    end else begin
      ex_valid    <= 1'b1;
      ex_alu_op   <= dec.alu_op;
      ex_opa      <= dec.reads_a ? byp_a : '0;
      ex_opb      <= dec.reads_b ? byp_b : '0;
      ex_rw       <= ra;
      ex_wr_en    <= dec.wr_en;
      ex_is_load  <= dec.is_load;
      ex_is_store <= dec.is_store;
      ex_illegal  <= dec.illegal;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// +------------------------------------------------------------------+
// | tb_decode_stage : scoreboard bench with behavioural ISA model    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_decode_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [7:0] id_instr;
  logic       flush;
  logic [1:0] rf_ra, rf_rb;
  logic [7:0] rf_rda, rf_rdb;
  logic       mem_wr_en;
  logic [1:0] mem_wr_addr;
  logic [7:0] mem_wr_data;
  logic       mem_is_load;
  logic       wb_wr_en;
  logic [1:0] wb_wr_addr;
  logic [7:0] wb_wr_data;
  logic       stall;
  logic       ex_valid;
  logic [2:0] ex_alu_op;
  logic [7:0] ex_opa, ex_opb;
  logic [1:0] ex_rw;
  logic       ex_wr_en, ex_is_load, ex_is_store, ex_illegal;

  always #5 clk = ~clk;

  logic [7:0] regs [4];
  assign rf_rda = regs[rf_ra];
  assign rf_rdb = regs[rf_rb];

  decode_stage #(.DATA_W(8), .RADDR_W(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .flush(flush),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_rda(rf_rda), .rf_rdb(rf_rdb),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_is_load(mem_is_load), .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr),
    .wb_wr_data(wb_wr_data), .stall(stall), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
    .ex_opa(ex_opa), .ex_opb(ex_opb), .ex_rw(ex_rw), .ex_wr_en(ex_wr_en),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_illegal(ex_illegal)
  );

  typedef struct packed {
    logic       valid;
    logic       full;
    logic       chk_a;
    logic       chk_b;
    logic       chk_rw;
    logic [2:0] alu;
    logic [7:0] opa;
    logic [7:0] opb;
    logic [1:0] rw;
    logic       wr_en;
    logic       ld;
    logic       st;
    logic       ill;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  // Model of what sits in ID/EX, kept from the model's own predictions.
  bit         m_known = 0;
  bit         m_ex_valid = 0;
  bit         m_ex_ld = 0;
  logic [1:0] m_ex_rw = 2'd0;
  bit         last_stall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit uses_a(input logic [3:0] op);
    return (op >= 4'd2 && op <= 4'd5) || op == 4'd7;
  endfunction

  function automatic bit uses_b(input logic [3:0] op);
    return op >= 4'd1 && op <= 4'd7;
  endfunction

  function automatic bit reads_reg(input logic [7:0] ins, input logic [1:0] r);
    return (uses_a(ins[7:4]) && ins[3:2] == r) || (uses_b(ins[7:4]) && ins[1:0] == r);
  endfunction

  function automatic logic [7:0] value_of(input logic [1:0] r);
    if (mem_wr_en && !mem_is_load && mem_wr_addr == r) return mem_wr_data;
    if (wb_wr_en && wb_wr_addr == r) return wb_wr_data;
    return regs[r];
  endfunction

  task automatic cycle();
    exp_t       e;
    bit         hz, exp_stall;
    logic [3:0] op;
    #1;
    op = id_instr[7:4];
    hz = id_valid && ((m_ex_valid && m_ex_ld && reads_reg(id_instr, m_ex_rw)) ||
                      (mem_wr_en && mem_is_load && reads_reg(id_instr, mem_wr_addr)));
    exp_stall = hz && !flush;
    if (m_known) chk("stall", 32'(stall), 32'(exp_stall));
    chk("rf_ra", 32'(rf_ra), 32'(id_instr[3:2]));
    chk("rf_rb", 32'(rf_rb), 32'(id_instr[1:0]));
    e = '0;
    if (rst) begin
      e.full = 1'b1;
      m_ex_valid = 0; m_ex_ld = 0; m_known = 1;
    end else if (flush || exp_stall || !id_valid) begin
      m_ex_valid = 0; m_ex_ld = 0;
    end else begin
      e.valid  = 1'b1;
      e.ill    = op >= 4'd8;
      e.wr_en  = op >= 4'd1 && op <= 4'd6;
      e.ld     = op == 4'd6;
      e.st     = op == 4'd7;
      e.alu    = (op >= 4'd2 && op <= 4'd5) ? 3'(op - 4'd1) : 3'd0;
      e.chk_a  = uses_a(op) || op == 4'd1;
      e.opa    = uses_a(op) ? value_of(id_instr[3:2]) : 8'd0;
      e.chk_b  = uses_b(op);
      e.opb    = value_of(id_instr[1:0]);
      e.chk_rw = e.wr_en;
      e.rw     = id_instr[3:2];
      m_ex_valid = 1; m_ex_ld = e.ld; m_ex_rw = id_instr[3:2];
    end
    q.push_back(e);
    last_stall = exp_stall;
    @(posedge clk);
    #2;
    if (wb_wr_en) regs[wb_wr_addr] = wb_wr_data;
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("ex_valid", 32'(ex_valid), 32'(mon_e.valid));
      chk("ex_wr_en", 32'(ex_wr_en), 32'(mon_e.wr_en));
      chk("ex_is_load", 32'(ex_is_load), 32'(mon_e.ld));
      chk("ex_is_store", 32'(ex_is_store), 32'(mon_e.st));
      if (mon_e.valid || mon_e.full) begin
        chk("ex_alu_op", 32'(ex_alu_op), 32'(mon_e.alu));
        chk("ex_illegal", 32'(ex_illegal), 32'(mon_e.ill));
      end
      if (mon_e.full) begin
        chk("rst_opa", 32'(ex_opa), 32'd0);
        chk("rst_opb", 32'(ex_opb), 32'd0);
        chk("rst_rw", 32'(ex_rw), 32'd0);
      end
      if (mon_e.chk_a) chk("ex_opa", 32'(ex_opa), 32'(mon_e.opa));
      if (mon_e.chk_b) chk("ex_opb", 32'(ex_opb), 32'(mon_e.opb));
      if (mon_e.chk_rw) chk("ex_rw", 32'(ex_rw), 32'(mon_e.rw));
    end
  end

  task automatic idle();
    rst = 0; id_valid = 0; flush = 0;
    mem_wr_en = 0; mem_is_load = 0; mem_wr_addr = 2'd0; mem_wr_data = 8'($urandom);
    wb_wr_en = 0; wb_wr_addr = 2'd0; wb_wr_data = 8'($urandom);
  endtask

  task automatic issue(input logic [7:0] ins);
    id_valid = 1; id_instr = ins;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) regs[i] = 8'($urandom);
    idle();
    id_instr = 8'($urandom);
    id_valid = 1;
    rst = 1;
    @(negedge clk);
    // Reset with arbitrary instruction traffic
    cycle();
    rst = 1; issue(8'($urandom)); mem_wr_en = 1; cycle();

    // WB bypass: register file still shows the old R1
    idle(); regs[1] = 8'h05; wb_wr_en = 1; wb_wr_addr = 2'd1; wb_wr_data = 8'h09;
    issue(8'h21); cycle();

    // EX/MEM bypass wins over WB
    idle(); mem_wr_en = 1; mem_wr_addr = 2'd2; mem_wr_data = 8'h33;
    wb_wr_en = 1; wb_wr_addr = 2'd2; wb_wr_data = 8'h44;
    issue(8'h12); cycle();

    // Load-use: LD R1,[R2] then ADD R0,R1 stalls twice, then takes WB data
    idle(); issue(8'h66); cycle();
    idle(); issue(8'h21); cycle();
    idle(); issue(8'h21); mem_wr_en = 1; mem_wr_addr = 2'd1; mem_is_load = 1; cycle();
    idle(); issue(8'h21); wb_wr_en = 1; wb_wr_addr = 2'd1; wb_wr_data = 8'h5A; cycle();

    // Flush on the first stall cycle
    idle(); issue(8'h66); cycle();
    idle(); issue(8'h21); flush = 1; cycle();
    idle(); cycle();

    // Reset while stalled drops the instruction
    idle(); issue(8'h66); cycle();
    idle(); issue(8'h21); rst = 1; cycle();
    idle(); issue(8'h21); cycle();

    // Reserved opcode and ST reading ra behind a load
    idle(); issue(8'hA5); cycle();
    idle(); issue(8'h6C); cycle();
    idle(); issue(8'h7C); cycle();
    idle(); cycle();

    // Randomized traffic; IF/ID holds its instruction while stalled
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      if (!last_stall) begin
        id_valid = ($urandom_range(0, 3) != 0);
        id_instr = 8'($urandom);
      end
      flush       = ($urandom_range(0, 7) == 0);
      mem_wr_en   = 1'($urandom_range(0, 1));
      mem_wr_addr = 2'($urandom);
      mem_wr_data = 8'($urandom);
      mem_is_load = ($urandom_range(0, 3) == 0);
      wb_wr_en    = 1'($urandom_range(0, 1));
      wb_wr_addr  = 2'($urandom);
      wb_wr_data  = 8'($urandom);
      cycle();
    end

    idle();
    cycle();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
